// File: rtl/penc_pkg.sv
// Shared types and helpers for the penc stream priority encoder family.
// Optional merge path is selected with the PENC_MERGE_EN macro in the top.
`timescale 1ns/1ps

package penc_pkg;

    typedef enum logic {
        PENC_IDLE  = 1'b0,
        PENC_DRAIN = 1'b1
    } penc_state_t;

    // Widest request vector the helper below accepts; callers zero-extend.
    localparam int PENC_MAX_N = 64;

    // True when exactly one bit is set: non-zero and clearing the lowest set bit leaves nothing.
    function automatic logic popcount_is_one(input logic [PENC_MAX_N-1:0] v);
        return (v != '0) && ((v & (v - PENC_MAX_N'(1))) == '0);
    endfunction

endpackage

// File: rtl/penc_stream_encoder_if.sv
// Request-in / index-out handshake bundle for penc_stream_encoder.
// slave = encoder side, master = request source and index consumer.
`timescale 1ns/1ps

interface penc_stream_if #(
    parameter int N = 4
);
    localparam int W = $clog2(N);

    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] in_req;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_idx;
    logic         out_last;

    modport slave (
        input  in_valid, in_req, out_ready,
        output in_ready, out_valid, out_idx, out_last
    );

    modport master (
        output in_valid, in_req, out_ready,
        input  in_ready, out_valid, out_idx, out_last
    );

endinterface

// File: rtl/penc_prio_find.sv
// Combinational MSB-first finder: index of the highest set bit plus an any-set flag.
// Purely combinational so arbiters can reuse it unchanged.
`timescale 1ns/1ps

module penc_prio_find #(
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    output logic [W-1:0] idx,
    output logic         any
);

    // Ascending scan: the last hit wins, so the highest set bit ends up in idx.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        idx = '0;
        for (int i = 0; i < N; i++) begin
            if (req[i]) begin
                idx = W'(i);
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/penc_stream_encoder.sv
// Clocked priority encoder: captures a request vector and streams out each set index, MSB first.
// Define PENC_MERGE_EN to keep accepting requests while draining and merge them into pending.
`timescale 1ns/1ps

module penc_stream_encoder
    import penc_pkg::*;
#(
    parameter int N = 4
) (
    input  logic             clk,
    input  logic             rst,
    penc_stream_if.slave     bus,
    output logic             busy
);

    localparam int W = $clog2(N);

    penc_state_t  state_q, state_d;
    logic [N-1:0] pending_q, pending_d;

    logic [W-1:0] top_idx;
    logic         pending_any;
    logic [N-1:0] served;
    logic         accept;
    logic         fire;

    penc_prio_find #(
        .N (N),
        .W (W)
    ) u_find (
        .req (pending_q),
        .idx (top_idx),
        .any (pending_any)
    );

    // Outputs decode only registered state, so there is no in->out combinational path.
    assign bus.out_valid = (state_q == PENC_DRAIN);
    assign bus.out_idx   = top_idx;
    assign bus.out_last  = popcount_is_one(PENC_MAX_N'(pending_q));
    assign busy          = pending_any;

`ifdef PENC_MERGE_EN
    assign bus.in_ready = 1'b1;
`else
    assign bus.in_ready = (state_q == PENC_IDLE);
`endif

    assign accept = bus.in_valid && bus.in_ready;
    assign fire   = bus.out_valid && bus.out_ready;

    always_comb begin
        served          = '0;
        served[top_idx] = 1'b1;
    end

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        unique case (state_q)
            PENC_IDLE: begin
                // An all-zero request is consumed but leaves nothing to drain.
                if (accept && (bus.in_req != '0)) begin
                    pending_d = bus.in_req;
                    state_d   = PENC_DRAIN;
                end
            end
            PENC_DRAIN: begin
                if (fire) begin
                    pending_d = pending_q & ~served;
                end
`ifdef PENC_MERGE_EN
                // A merged bit equal to the one just served is re-queued on purpose.
                if (accept) begin
                    pending_d = pending_d | bus.in_req;
                end
`endif
                if (pending_d == '0) begin
                    state_d = PENC_IDLE;
                end
            end
            default: begin
                state_d   = PENC_IDLE;
                pending_d = '0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= PENC_IDLE;
            pending_q <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
        end
    end

endmodule
